// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide memory bus arbiter.
// Build option: MEM_ARB_LSB_PRIORITY_EN selects fixed LSB priority instead of round-robin.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Upper address bits that mark the UART I/O window.
  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  // Latched request being sequenced onto the bus.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
    logic              is_lsb;
  } req_t;

  // Byte count for a size code; the illegal code 3 is treated as a word.
  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = CNT_W'(1);
      SIZE_H:  size_bytes = CNT_W'(2);
      default: size_bytes = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way requester selector between ICache and LSB.
// Build option: MEM_ARB_LSB_PRIORITY_EN turns it into fixed LSB-first priority.
module mem_arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic ic_req_i,
  input  logic lsb_req_i,
`ifndef MEM_ARB_LSB_PRIORITY_EN
  input  logic last_lsb_i,
`endif
  output logic gnt_ic_o_c,
  output logic gnt_lsb_o_c
);

`ifdef MEM_ARB_LSB_PRIORITY_EN
  // LSB always wins a tie.
  always_comb begin
    gnt_lsb_o_c = lsb_req_i;
    gnt_ic_o_c  = ic_req_i && !lsb_req_i;
  end
`else
  // On a tie the requester not granted last time wins.
  always_comb begin
    gnt_lsb_o_c = lsb_req_i && (!ic_req_i || !last_lsb_i);
    gnt_ic_o_c  = ic_req_i && (!lsb_req_i || last_lsb_i);
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates ICache fetches and LSB loads/stores onto the byte-wide memory bus,
// sequencing per-byte cycles and reassembling read data little-endian.
// Build option: MEM_ARB_LSB_PRIORITY_EN gives LSB fixed priority over ICache.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        clear,
  input  logic        ic_valid,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        lsb_valid,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic [1:0]  lsb_size,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cap_q, cap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              issued_q, issued_d;
  logic              ic_done_q, ic_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [DATA_W-1:0] ic_data_q, ic_data_d;
  logic [DATA_W-1:0] lsb_rdata_q, lsb_rdata_d;

  logic              gnt_ic, gnt_lsb;
  logic              can_grant;
  logic [CNT_W-1:0]  nbytes;
  logic [CNT_W-1:0]  rd_idx;
  logic              io_stall;

  assign nbytes    = size_bytes(req_q.size);
  // Byte currently addressed: one past the last captured byte while a capture is in flight.
  assign rd_idx    = cap_q + CNT_W'(issued_q);
  assign io_stall  = (req_q.addr[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign can_grant = (state_q == ST_IDLE) && !ic_done_q && !lsb_done_q && !clear;

`ifdef MEM_ARB_LSB_PRIORITY_EN
  mem_arb_rr_pick u_pick (
    .ic_req_i    (ic_valid),
    .lsb_req_i   (lsb_valid),
    .gnt_ic_o_c  (gnt_ic),
    .gnt_lsb_o_c (gnt_lsb)
  );
`else
  logic rr_lsb_q, rr_lsb_d;

  mem_arb_rr_pick u_pick (
    .ic_req_i    (ic_valid),
    .lsb_req_i   (lsb_valid),
    .last_lsb_i  (rr_lsb_q),
    .gnt_ic_o_c  (gnt_ic),
    .gnt_lsb_o_c (gnt_lsb)
  );

  // Remember who was granted last; reset favours LSB on the first tie.
  always_comb begin
    rr_lsb_d = rr_lsb_q;
    if (can_grant && (gnt_ic || gnt_lsb)) rr_lsb_d = gnt_lsb;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rr_lsb_q <= 1'b0;
    else if (rdy) rr_lsb_q <= rr_lsb_d;
  end
`endif

  // Next-state and completion logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cap_d       = cap_q;
    data_d      = data_q;
    issued_d    = 1'b0;
    ic_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    ic_data_d   = ic_data_q;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (can_grant && (gnt_ic || gnt_lsb)) begin
          req_d.is_lsb = gnt_lsb;
          req_d.addr   = gnt_lsb ? lsb_addr : ic_addr;
          req_d.size   = gnt_lsb ? lsb_size : SIZE_W;
          req_d.wdata  = gnt_lsb ? lsb_wdata : '0;
          cap_d        = '0;
          data_d       = '0;
          state_d      = (gnt_lsb && lsb_wr) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else begin
          if (issued_q) begin
            data_d[{cap_q[1:0], 3'b000} +: BYTE_W] = mem_din;
            cap_d = cap_q + CNT_W'(1);
            if (cap_q == nbytes - CNT_W'(1)) begin
              state_d = ST_IDLE;
              if (req_q.is_lsb) begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = data_d;
              end else begin
                ic_done_d = 1'b1;
                ic_data_d = data_d;
              end
            end
          end
          issued_d = (rd_idx < nbytes);
        end
      end
      ST_WRITE: begin
        if (!io_stall) begin
          cap_d = cap_q + CNT_W'(1);
          if (cap_q == nbytes - CNT_W'(1)) begin
            state_d    = ST_IDLE;
            lsb_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Main registers; everything freezes while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cap_q       <= '0;
      data_q      <= '0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      ic_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      req_q       <= req_d;
      cap_q       <= cap_d;
      data_q      <= data_d;
      ic_done_q   <= ic_done_d;
      lsb_done_q  <= lsb_done_d;
      ic_data_q   <= ic_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  // Address issued with rdy high; a rdy-low cycle drops the pending capture so it is re-driven.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) issued_q <= 1'b0;
    else      issued_q <= rdy && issued_d;
  end

  // Bus pin drive from the current state.
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    case (state_q)
      ST_READ: begin
        if (rd_idx < nbytes) mem_a = req_q.addr + ADDR_W'(rd_idx);
      end
      ST_WRITE: begin
        mem_a    = req_q.addr + ADDR_W'(cap_q);
        mem_dout = req_q.wdata[{cap_q[1:0], 3'b000} +: BYTE_W];
        mem_wr   = rdy && !io_stall;
      end
      default: ;
    endcase
  end

  assign ic_done   = ic_done_q;
  assign ic_data   = ic_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic
// checked against a transaction-level memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        clear;
  logic        ic_valid;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        lsb_valid;
  logic        lsb_wr;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [1:0]  lsb_size;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] bus_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  logic [31:0] prev_a = 32'h0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .clear(clear),
    .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_size(lsb_size), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    init_byte = a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    bus_rd = bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    ref_rd = ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Little-endian, zero-extended value of n bytes at a.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < n; i++) r = r | (32'(ref_rd(a + 32'(i))) << (8 * i));
    ref_load = r;
  endfunction

  function automatic logic [31:0] bus_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < n; i++) r = r | (32'(bus_rd(a + 32'(i))) << (8 * i));
    bus_load = r;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = wd >> (8 * i);
      ref_mem[a + 32'(i)] = t[7:0];
    end
  endtask

  // Memory device: data for the address seen in one cycle is presented in the next.
  initial begin
    mem_din = 8'h0;
    forever begin
      @(negedge clk);
      mem_din = bus_rd(prev_a);
      prev_a  = mem_a;
      if (mem_wr) bus_mem[mem_a] = mem_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  int n_ic, n_lsb, ic_age, lsb_age, sz_n, k;
  logic ic_pend, lsb_pend, lsb_is_wr, seen_l, seen_i;
  logic [31:0] ic_exp, lsb_exp, la;
  int order[$];

  initial begin
    rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
    ic_valid = 1'b0; ic_addr = '0; lsb_valid = 1'b0; lsb_wr = 1'b0;
    lsb_addr = '0; lsb_wdata = '0; lsb_size = 2'd0;
    bus_mem[32'h1000] = 8'h13; bus_mem[32'h1001] = 8'h05;
    bus_mem[32'h1002] = 8'h00; bus_mem[32'h1003] = 8'h00;
    ref_mem[32'h1000] = 8'h13; ref_mem[32'h1001] = 8'h05;
    ref_mem[32'h1002] = 8'h00; ref_mem[32'h1003] = 8'h00;

    // Reset state
    step();
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wr", 32'(mem_wr), 32'h0);
    chk("rst mem_dout", 32'(mem_dout), 32'h0);
    chk("rst ic_done", 32'(ic_done), 32'h0);
    chk("rst lsb_done", 32'(lsb_done), 32'h0);
    chk("rst ic_data", ic_data, 32'h0);
    chk("rst lsb_rdata", lsb_rdata, 32'h0);
    do_reset();

    // IC word fetch at 0x1000
    ic_addr = 32'h1000; ic_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      settle();
      if (i < 4) begin
        chk("fetch mem_a", mem_a, 32'h1000 + 32'(i));
        chk("fetch mem_wr", 32'(mem_wr), 32'h0);
      end
      if (i == 5) begin
        chk("fetch ic_done", 32'(ic_done), 32'h1);
        chk("fetch ic_data", ic_data, 32'h00000513);
        ic_valid = 1'b0;
      end else begin
        chk("fetch ic_done low", 32'(ic_done), 32'h0);
      end
    end

    // Simultaneous requests: LSB first, then alternation
    do_reset();
    ic_addr = 32'h1000; ic_valid = 1'b1;
    lsb_addr = 32'h2000; lsb_size = 2'd2; lsb_wr = 1'b0; lsb_valid = 1'b1;
    for (int i = 0; i < 80 && order.size() < 4; i++) begin
      step();
      settle();
      if (lsb_done) begin
        chk("arb lsb data", lsb_rdata, ref_load(32'h2000, 4));
        order.push_back(1);
      end
      if (ic_done) begin
        chk("arb ic data", ic_data, 32'h00000513);
        order.push_back(0);
      end
    end
    ic_valid = 1'b0; lsb_valid = 1'b0;
    chk("arb completions", 32'(order.size()), 32'd4);
    while (order.size() < 4) order.push_back(-1);
    chk("arb order0", 32'(order[0]), 32'd1);
    chk("arb order1", 32'(order[1]), 32'd0);
    chk("arb order2", 32'(order[2]), 32'd1);
    chk("arb order3", 32'(order[3]), 32'd0);
    step(); step();

    // Half store to I/O window with the UART buffer full for 3 cycles
    io_buffer_full = 1'b1;
    lsb_addr = 32'h00030000; lsb_wdata = 32'h0000AABB; lsb_size = 2'd1;
    lsb_wr = 1'b1; lsb_valid = 1'b1;
    ref_store(32'h00030000, 32'h0000AABB, 2);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 3) io_buffer_full = 1'b0;
      settle();
      if (i < 3) chk("io stall mem_wr", 32'(mem_wr), 32'h0);
      if (i == 3) begin
        chk("io wr0 mem_wr", 32'(mem_wr), 32'h1);
        chk("io wr0 mem_a", mem_a, 32'h00030000);
        chk("io wr0 mem_dout", 32'(mem_dout), 32'hBB);
      end
      if (i == 4) begin
        chk("io wr1 mem_wr", 32'(mem_wr), 32'h1);
        chk("io wr1 mem_a", mem_a, 32'h00030001);
        chk("io wr1 mem_dout", 32'(mem_dout), 32'hAA);
        chk("io early done", 32'(lsb_done), 32'h0);
      end
      if (i == 5) begin
        chk("io lsb_done", 32'(lsb_done), 32'h1);
        chk("io done mem_wr", 32'(mem_wr), 32'h0);
        lsb_valid = 1'b0;
      end
    end
    step();
    chk("io bytes", bus_load(32'h00030000, 2), 32'h0000AABB);

    // Clear in second cycle of an IC fetch with a pending LSB load
    step();
    ic_addr = 32'h1000; ic_valid = 1'b1;
    step();
    lsb_addr = 32'h2000; lsb_size = 2'd2; lsb_wr = 1'b0; lsb_valid = 1'b1;
    step();
    clear = 1'b1;
    settle();
    chk("clr c1 ic_done", 32'(ic_done), 32'h0);
    step();
    clear = 1'b0;
    settle();
    chk("clr idle mem_a", mem_a, 32'h0);
    chk("clr no ic_done", 32'(ic_done), 32'h0);
    step();
    settle();
    chk("clr lsb granted", mem_a, 32'h2000);
    seen_l = 1'b0; seen_i = 1'b0;
    for (int i = 0; i < 40 && !(seen_l && seen_i); i++) begin
      step();
      settle();
      if (lsb_done) begin
        chk("clr lsb data", lsb_rdata, ref_load(32'h2000, 4));
        lsb_valid = 1'b0; seen_l = 1'b1;
      end
      if (ic_done) begin
        chk("clr ic after lsb", 32'(seen_l), 32'h1);
        chk("clr ic data", ic_data, 32'h00000513);
        ic_valid = 1'b0; seen_i = 1'b1;
      end
    end
    chk("clr both done", 32'(seen_l && seen_i), 32'h1);
    step(); step();

    // rdy low for two cycles during a word load
    lsb_addr = 32'h2100; lsb_size = 2'd2; lsb_wr = 1'b0; lsb_valid = 1'b1;
    step(); settle();
    chk("rdy c0 mem_a", mem_a, 32'h2100);
    step(); settle();
    chk("rdy c1 mem_a", mem_a, 32'h2101);
    step(); rdy = 1'b0; settle();
    chk("rdy low mem_wr", 32'(mem_wr), 32'h0);
    step(); settle();
    step(); rdy = 1'b1; settle();
    chk("rdy redrive mem_a", mem_a, 32'h2101);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      step(); settle();
      if (lsb_done) begin
        k = i;
        chk("rdy load data", lsb_rdata, ref_load(32'h2100, 4));
        lsb_valid = 1'b0;
      end
    end
    chk("rdy done latency", 32'(k), 32'd4);
    step(); step();

    // Reset in the middle of a word store
    lsb_addr = 32'h2200; lsb_wdata = 32'h11223344; lsb_size = 2'd2;
    lsb_wr = 1'b1; lsb_valid = 1'b1;
    step(); step(); settle();
    chk("mid-store mem_wr", 32'(mem_wr), 32'h1);
    rst = 1'b0;
    #1;
    chk("rstw mem_a", mem_a, 32'h0);
    chk("rstw mem_wr", 32'(mem_wr), 32'h0);
    chk("rstw mem_dout", 32'(mem_dout), 32'h0);
    chk("rstw lsb_done", 32'(lsb_done), 32'h0);
    lsb_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    lsb_addr = 32'h2002; lsb_size = 2'd1; lsb_wr = 1'b0; lsb_valid = 1'b1;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      step(); settle();
      if (lsb_done) begin
        k = i;
        chk("post-rst load", lsb_rdata, ref_load(32'h2002, 2));
        lsb_valid = 1'b0;
      end
    end
    chk("post-rst done", 32'(k != 0), 32'h1);
    step();

    // Randomized traffic
    n_ic = 0; n_lsb = 0; ic_pend = 1'b0; lsb_pend = 1'b0; ic_age = 0; lsb_age = 0;
    lsb_is_wr = 1'b0; sz_n = 1; la = '0; ic_exp = '0; lsb_exp = '0;
    for (int cyc = 0; cyc < 6000 && (n_ic < 40 || n_lsb < 60); cyc++) begin
      step();
      rdy            = ($urandom_range(0, 9) != 0);
      clear          = ($urandom_range(0, 15) == 0);
      io_buffer_full = 1'($urandom_range(0, 1));
      settle();
      if (!rdy) chk("rand rdy-low mem_wr", 32'(mem_wr), 32'h0);
      if (rdy && ic_done) begin
        chk("rand ic_done pending", 32'(ic_pend), 32'h1);
        if (ic_pend) chk("rand ic_data", ic_data, ic_exp);
        ic_valid = 1'b0; ic_pend = 1'b0; n_ic++;
      end
      if (rdy && lsb_done) begin
        chk("rand lsb_done pending", 32'(lsb_pend), 32'h1);
        if (lsb_pend && lsb_is_wr) chk("rand store bytes", bus_load(la, sz_n), ref_load(la, sz_n));
        if (lsb_pend && !lsb_is_wr) chk("rand lsb_rdata", lsb_rdata, lsb_exp);
        lsb_valid = 1'b0; lsb_pend = 1'b0; n_lsb++;
      end
      if (ic_pend) begin
        ic_age++;
        if (ic_age > 400) begin
          chk("rand ic timeout", 32'(ic_age), 32'd0);
          ic_valid = 1'b0; ic_pend = 1'b0;
        end
      end
      if (lsb_pend) begin
        lsb_age++;
        if (lsb_age > 400) begin
          chk("rand lsb timeout", 32'(lsb_age), 32'd0);
          lsb_valid = 1'b0; lsb_pend = 1'b0;
        end
      end
      if (!ic_pend && $urandom_range(0, 3) == 0) begin
        ic_addr  = 32'h1000 + 32'($urandom_range(0, 252));
        ic_exp   = ref_load(ic_addr, 4);
        ic_valid = 1'b1; ic_pend = 1'b1; ic_age = 0;
      end
      if (!lsb_pend && $urandom_range(0, 2) == 0) begin
        lsb_is_wr = 1'($urandom_range(0, 1));
        lsb_size  = 2'($urandom_range(0, 2));
        sz_n      = (lsb_size == 2'd0) ? 1 : (lsb_size == 2'd1) ? 2 : 4;
        if (lsb_is_wr && $urandom_range(0, 3) == 0) la = 32'h00030000 + 32'($urandom_range(0, 3));
        else                                        la = 32'h2000 + 32'($urandom_range(0, 255));
        lsb_addr  = la;
        lsb_wr    = lsb_is_wr;
        lsb_wdata = $urandom;
        if (lsb_is_wr) ref_store(la, lsb_wdata, sz_n);
        else           lsb_exp = ref_load(la, sz_n);
        lsb_valid = 1'b1; lsb_pend = 1'b1; lsb_age = 0;
      end
    end
    chk("rand coverage", 32'(n_ic >= 40 && n_lsb >= 60), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
